// File: rtl/e203_exu_wbck_buf.sv
// Write-back arbiter: an in-order long-pipe FIFO has priority over the ALU onto the single regfile write port.
// Optional last-write forwarding registers are built when E203_WBCK_FWD_EN is defined.
module e203_exu_wbck_buf #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RFIDX_W     = 5,
  parameter int unsigned LONGP_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,

  input  logic                           alu_wbck_i_valid,
  output logic                           alu_wbck_i_ready,
  input  logic [XLEN-1:0]                alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0]             alu_wbck_i_rdidx,

  input  logic                           longp_wbck_i_valid,
  output logic                           longp_wbck_i_ready,
  input  logic                           longp_wbck_i_rdwen,
  input  logic [XLEN-1:0]                longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0]             longp_wbck_i_rdidx,

  output logic                           rf_wbck_o_ena,
  output logic [RFIDX_W-1:0]             rf_wbck_o_rdidx,
  output logic [XLEN-1:0]                rf_wbck_o_wdat,

  output logic [$clog2(LONGP_DEPTH):0]   longp_cnt,

  output logic                           fwd_vld,
  output logic [RFIDX_W-1:0]             fwd_idx,
  output logic [XLEN-1:0]                fwd_dat
);

  localparam int unsigned PTR_W = $clog2(LONGP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [RFIDX_W-1:0] rdidx;
    logic [XLEN-1:0]    wdat;
  } entry_t;

  entry_t             fifo_mem [LONGP_DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic [CNT_W-1:0]   cnt;
  logic               push;
  logic               pop;
  entry_t             head;

  // Handshakes, arbitration and regfile port mux; any queued entry always wins.
  always_comb begin
    longp_wbck_i_ready = (cnt != CNT_W'(LONGP_DEPTH));
    alu_wbck_i_ready   = (cnt == '0);
    pop                = (cnt != '0);
    push               = longp_wbck_i_valid & longp_wbck_i_ready & longp_wbck_i_rdwen;
    head               = fifo_mem[rptr];
    rf_wbck_o_ena      = 1'b0;
    rf_wbck_o_rdidx    = alu_wbck_i_rdidx;
    rf_wbck_o_wdat     = alu_wbck_i_wdat;
    if (pop) begin
      rf_wbck_o_rdidx = head.rdidx;
      rf_wbck_o_wdat  = head.wdat;
      rf_wbck_o_ena   = (head.rdidx != '0);
    end else begin
      rf_wbck_o_ena   = alu_wbck_i_valid & (alu_wbck_i_rdidx != '0);
    end
    // Keep the write port quiet while reset is held, whatever the ALU presents.
    rf_wbck_o_ena = rf_wbck_o_ena & rst_n;
  end

  assign longp_cnt = cnt;

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is only read behind a valid count, so it is left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr] <= '{rdidx: longp_wbck_i_rdidx, wdat: longp_wbck_i_wdat};
    end
  end

`ifdef E203_WBCK_FWD_EN
  // One-cycle copy of the last enabled write for decode-stage bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_vld <= 1'b0;
      fwd_idx <= '0;
      fwd_dat <= '0;
    end else begin
      fwd_vld <= rf_wbck_o_ena;
      fwd_idx <= rf_wbck_o_ena ? rf_wbck_o_rdidx : '0;
      fwd_dat <= rf_wbck_o_ena ? rf_wbck_o_wdat  : '0;
    end
  end
`else
  assign fwd_vld = 1'b0;
  assign fwd_idx = '0;
  assign fwd_dat = '0;
`endif

endmodule
